mp_adder_stream: RTL and testbench



---
 rtl/mp_adder_stream.sv | 156 +++++++++++++++
 tb/tb_mp_adder_stream.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/mp_adder_stream.sv
// Word-serial front end for mp_adder: assembles two operands from a valid/ready
// input stream, starts the adder, and streams the captured result back out.
module mp_adder_stream #(
  parameter int OPERAND_WIDTH = 512,
  parameter int WORD_WIDTH    = 32,
  parameter int N_WORDS       = OPERAND_WIDTH / WORD_WIDTH
) (
  input  logic                     iClk,
  input  logic                     iRstn,
  input  logic [WORD_WIDTH-1:0]    iInData,
  input  logic                     iInValid,
  input  logic                     iInCmd,
  output logic                     oInReady,
  output logic                     oStart,
  output logic                     oCommand,
  output logic [OPERAND_WIDTH-1:0] oOpA,
  output logic [OPERAND_WIDTH-1:0] oOpB,
  input  logic [OPERAND_WIDTH:0]   iRes,
  input  logic                     iDone,
  output logic [WORD_WIDTH-1:0]    oOutData,
  output logic                     oOutValid,
  input  logic                     iOutReady,
  output logic                     oOutLast,
  output logic                     oBusy
);

  localparam int CNT_WIDTH = $clog2(N_WORDS + 1) + 1;
  localparam logic [CNT_WIDTH-1:0] LAST_IDX  = CNT_WIDTH'(N_WORDS - 1);
  localparam logic [CNT_WIDTH-1:0] CARRY_IDX = CNT_WIDTH'(N_WORDS);

  typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_B, START, WAIT, SEND} stateT;

  stateT                  state;
  logic [CNT_WIDTH-1:0]   cnt;
  logic [OPERAND_WIDTH:0] resReg;
  logic                   inXfer;
  logic                   outXfer;
  logic [CNT_WIDTH-1:0]   nextIdx;
  logic [WORD_WIDTH-1:0]  nextWord;

  assign inXfer  = iInValid && oInReady;
  assign outXfer = oOutValid && iOutReady;
  assign nextIdx = cnt + CNT_WIDTH'(1);
  assign oBusy   = (state != IDLE);

  // Result word to present after the current one; the final slot is the carry-out.
  always_comb begin
    // NOTE: default assignment first so no path through this block infers a latch.
    nextWord = '0;
    for (int k = 0; k < N_WORDS; k++) begin
      if (nextIdx == CNT_WIDTH'(k)) nextWord = resReg[k*WORD_WIDTH +: WORD_WIDTH];
    end
    if (nextIdx == CARRY_IDX) nextWord = WORD_WIDTH'(resReg[OPERAND_WIDTH]);
  end

  // NOTE: all state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge iClk or negedge iRstn) begin
    if (!iRstn) begin
      state     <= IDLE;
      cnt       <= '0;
      resReg    <= '0;
      oInReady  <= 1'b0;
      oStart    <= 1'b0;
      oCommand  <= 1'b0;
      oOpA      <= '0;
      oOpB      <= '0;
      oOutData  <= '0;
      oOutValid <= 1'b0;
      oOutLast  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          oInReady <= 1'b1;
          if (inXfer) begin
            oOpA[WORD_WIDTH-1:0] <= iInData;
            oCommand             <= iInCmd;
            if (N_WORDS == 1) begin
              cnt   <= '0;
              state <= LOAD_B;
            end else begin
              cnt   <= CNT_WIDTH'(1);
              state <= LOAD_A;
            end
          end
        end

        LOAD_A: begin
          if (inXfer) begin
            for (int k = 0; k < N_WORDS; k++) begin
              if (cnt == CNT_WIDTH'(k)) oOpA[k*WORD_WIDTH +: WORD_WIDTH] <= iInData;
            end
            if (cnt == LAST_IDX) begin
              cnt   <= '0;
              state <= LOAD_B;
            end else begin
              cnt <= nextIdx;
            end
          end
        end

        LOAD_B: begin
          if (inXfer) begin
            for (int k = 0; k < N_WORDS; k++) begin
              if (cnt == CNT_WIDTH'(k)) oOpB[k*WORD_WIDTH +: WORD_WIDTH] <= iInData;
            end
            if (cnt == LAST_IDX) begin
              cnt      <= '0;
              oInReady <= 1'b0;
              oStart   <= 1'b1;
              state    <= START;
            end else begin
              cnt <= nextIdx;
            end
          end
        end

        START: begin
          oStart <= 1'b0;
          state  <= WAIT;
        end

        // The adder keeps shifting iRes after done, so only the done cycle is valid.
        WAIT: begin
          if (iDone) begin
            resReg    <= iRes;
            cnt       <= '0;
            oOutData  <= iRes[WORD_WIDTH-1:0];
            oOutValid <= 1'b1;
            oOutLast  <= 1'b0;
            state     <= SEND;
          end
        end

        SEND: begin
          if (outXfer) begin
            if (oOutLast) begin
              cnt       <= '0;
              oOutData  <= '0;
              oOutValid <= 1'b0;
              oOutLast  <= 1'b0;
              oInReady  <= 1'b1;
              state     <= IDLE;
            end else begin
              cnt      <= nextIdx;
              oOutData <= nextWord;
              oOutLast <= (nextIdx == CARRY_IDX);
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mp_adder_stream.sv
// Directed bench for mp_adder_stream; the bench plays both the stream ends and
// a simple adder responder, and checks result words against hand-computed values.
module tb_mp_adder_stream;

  localparam int OW = 512;
  localparam int WW = 32;
  localparam int NW = OW / WW;

  logic          iClk;
  logic          iRstn;
  logic [WW-1:0] iInData;
  logic          iInValid;
  logic          iInCmd;
  logic          oInReady;
  logic          oStart;
  logic          oCommand;
  logic [OW-1:0] oOpA;
  logic [OW-1:0] oOpB;
  logic [OW:0]   iRes;
  logic          iDone;
  logic [WW-1:0] oOutData;
  logic          oOutValid;
  logic          iOutReady;
  logic          oOutLast;
  logic          oBusy;

  int checks = 0;
  int errors = 0;
  int startCount = 0;

  mp_adder_stream #(.OPERAND_WIDTH(OW), .WORD_WIDTH(WW)) dut (
    .iClk(iClk), .iRstn(iRstn),
    .iInData(iInData), .iInValid(iInValid), .iInCmd(iInCmd), .oInReady(oInReady),
    .oStart(oStart), .oCommand(oCommand), .oOpA(oOpA), .oOpB(oOpB),
    .iRes(iRes), .iDone(iDone),
    .oOutData(oOutData), .oOutValid(oOutValid), .iOutReady(iOutReady),
    .oOutLast(oOutLast), .oBusy(oBusy)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  always @(posedge iClk) if (oStart) startCount++;

  task automatic check(input string tag, input logic [OW:0] got, input logic [OW:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [OW:0] adderModel(input logic [OW-1:0] a, input logic [OW-1:0] b,
                                             input logic cmd);
    if (cmd) return {1'b0, a} + {1'b0, ~b} + (OW+1)'(1);
    return {1'b0, a} + {1'b0, b};
  endfunction

  task automatic pushWord(input logic [WW-1:0] d, input logic c, input int gap);
    int n;
    repeat (gap) begin
      @(negedge iClk);
      iInValid = 1'b0;
    end
    @(negedge iClk);
    iInValid = 1'b1;
    iInData  = d;
    iInCmd   = c;
    n = 0;
    while (!oInReady && n < 100) begin
      @(negedge iClk);
      n++;
    end
    check("inReadyWait", oInReady, 1);
    @(posedge iClk);
    #1;
    iInValid = 1'b0;
  endtask

  task automatic runTxn(input logic [OW-1:0] a, input logic [OW-1:0] b, input logic cmd,
                        input bit throttle, input int stallWord,
                        input logic [WW-1:0] expLo, input logic [WW-1:0] expMid,
                        input logic [WW-1:0] expLast);
    int startsBefore;
    int n;
    logic [543:0] garbage;
    logic [WW-1:0] hold;
    logic [WW-1:0] words [NW+1];
    logic          lasts [NW+1];
    logic [WW-1:0] exp;
    startsBefore = startCount;
    // Non-first words carry the opposite command to confirm only the first is sampled.
    for (int k = 0; k < NW; k++)
      pushWord(a[k*WW +: WW], (k == 0) ? cmd : ~cmd, throttle ? int'($urandom_range(0, 3)) : 0);
    for (int k = 0; k < NW; k++)
      pushWord(b[k*WW +: WW], ~cmd, throttle ? int'($urandom_range(0, 3)) : 0);
    check("startRise", oStart, 1);
    check("opA", oOpA, a);
    check("opB", oOpB, b);
    check("command", oCommand, cmd);
    check("inReadyLow", oInReady, 0);
    repeat (4) @(negedge iClk);
    check("opAHeld", oOpA, a);
    check("opBHeld", oOpB, b);
    check("commandHeld", oCommand, cmd);
    check("busyWait", oBusy, 1);
    check("noEarlyValid", oOutValid, 0);
    iRes  = adderModel(a, b, cmd);
    iDone = 1'b1;
    @(posedge iClk);
    #1;
    iDone = 1'b0;
    for (int k = 0; k < 17; k++) garbage[k*32 +: 32] = $urandom();
    iRes = garbage[OW:0];
    check("outValidRise", oOutValid, 1);
    for (int w = 0; w <= NW; w++) begin
      @(negedge iClk);
      if (w == stallWord) begin
        iOutReady = 1'b0;
        hold = oOutData;
        repeat (3) begin
          @(negedge iClk);
          check("stallHold", oOutData, hold);
        end
        iOutReady = 1'b1;
      end
      n = 0;
      while (!oOutValid && n < 50) begin
        @(negedge iClk);
        n++;
      end
      check("outValidWait", oOutValid, 1);
      words[w] = oOutData;
      lasts[w] = oOutLast;
      @(posedge iClk);
    end
    for (int w = 0; w <= NW; w++) begin
      exp = (w == 0) ? expLo : (w == NW) ? expLast : expMid;
      check($sformatf("word%0d", w), words[w], exp);
      check($sformatf("last%0d", w), lasts[w], (w == NW) ? 1'b1 : 1'b0);
    end
    @(negedge iClk);
    check("noExtraWord", oOutValid, 0);
    check("backToIdle", oInReady, 1);
    check("idleNotBusy", oBusy, 0);
    check("startPulses", startCount - startsBefore, 1);
  endtask

  task automatic checkResetOutputs(input string tag);
    check({tag, "InReady"}, oInReady, 0);
    check({tag, "Start"}, oStart, 0);
    check({tag, "Command"}, oCommand, 0);
    check({tag, "OpA"}, oOpA, 0);
    check({tag, "OpB"}, oOpB, 0);
    check({tag, "OutData"}, oOutData, 0);
    check({tag, "OutValid"}, oOutValid, 0);
    check({tag, "OutLast"}, oOutLast, 0);
    check({tag, "Busy"}, oBusy, 0);
  endtask

  initial begin
    logic [OW-1:0] allOnes;
    logic [OW-1:0] partA;
    allOnes   = '1;
    iRstn     = 1'b0;
    iInData   = '0;
    iInValid  = 1'b0;
    iInCmd    = 1'b0;
    iRes      = '0;
    iDone     = 1'b0;
    iOutReady = 1'b1;

    repeat (3) @(negedge iClk);
    checkResetOutputs("rst");
    iRstn = 1'b1;
    @(negedge iClk);
    check("readyAfterReset", oInReady, 1);

    // Add with carry: 1 + (2^512-1) = 2^512.
    runTxn(OW'(1), allOnes, 1'b0, 1'b0, -1, 32'h0, 32'h0, 32'h1);
    // Subtract without borrow.
    runTxn(OW'(5), OW'(3), 1'b1, 1'b0, -1, 32'h2, 32'h0, 32'h1);
    // Subtract with borrow.
    runTxn(OW'(3), OW'(5), 1'b1, 1'b0, -1, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0);
    // Same borrow case with input gaps and a 3-cycle output stall on word 7.
    runTxn(OW'(3), OW'(5), 1'b1, 1'b1, 7, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0);

    // iDone while idle is ignored.
    @(negedge iClk);
    iRes  = {1'b1, allOnes};
    iDone = 1'b1;
    @(negedge iClk);
    iDone = 1'b0;
    @(negedge iClk);
    check("idleDoneBusy", oBusy, 0);
    check("idleDoneValid", oOutValid, 0);
    check("idleDoneReady", oInReady, 1);

    // Abort after 10 A words, then a full 7 + 9.
    for (int k = 0; k < NW; k++) partA[k*WW +: WW] = 32'hA5A5_0000 + k;
    for (int k = 0; k < 10; k++) pushWord(partA[k*WW +: WW], 1'b1, 0);
    check("partialBusy", oBusy, 1);
    @(negedge iClk);
    iRstn = 1'b0;
    #1;
    checkResetOutputs("midRst");
    repeat (2) @(negedge iClk);
    iRstn = 1'b1;
    @(negedge iClk);
    check("readyAfterMidReset", oInReady, 1);
    check("noOutputAfterAbort", oOutValid, 0);
    runTxn(OW'(7), OW'(9), 1'b0, 1'b0, -1, 32'h10, 32'h0, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
